// File: rtl/ntt_bank_wb.sv
// NTT write-back stage: delays read-beat addresses to meet routed butterfly data and issues bank writes.
// Optional overrun checking is built only when WB_OVERRUN_CHK_EN is defined.
module ntt_bank_wb #(
    parameter int unsigned data_width = 12,
    parameter int unsigned addr_width = 7,
    parameter int unsigned LAT        = 13,
    parameter int unsigned GROUPS     = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  rd_valid,
    input  logic [addr_width-1:0] rd_addr_0,
    input  logic [addr_width-1:0] rd_addr_1,
    input  logic [addr_width-1:0] rd_addr_2,
    input  logic [addr_width-1:0] rd_addr_3,
    input  logic [data_width-1:0] d0,
    input  logic [data_width-1:0] d1,
    input  logic [data_width-1:0] d2,
    input  logic [data_width-1:0] d3,
    output logic                  wen,
    output logic [addr_width-1:0] waddr_0,
    output logic [addr_width-1:0] waddr_1,
    output logic [addr_width-1:0] waddr_2,
    output logic [addr_width-1:0] waddr_3,
    output logic [data_width-1:0] wdata_0,
    output logic [data_width-1:0] wdata_1,
    output logic [data_width-1:0] wdata_2,
    output logic [data_width-1:0] wdata_3,
    output logic                  busy,
    output logic                  stage_done,
    output logic                  err
);

    localparam int unsigned cnt_w = $clog2(GROUPS + 1);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(GROUPS - 1);
    localparam logic [cnt_w-1:0] cnt_max  = cnt_w'(GROUPS);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                              state_q;
    logic [cnt_w-1:0]                    cnt_q;
    logic [LAT-1:0]                      dl_valid_q;
    logic [LAT-1:0][4*addr_width-1:0]    dl_addr_q;
    logic                                line_valid;
    logic [4*addr_width-1:0]             line_addr;

    assign line_valid = dl_valid_q[LAT-1];
    assign line_addr  = dl_addr_q[LAT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dl_valid_q <= '0;
            dl_addr_q  <= '0;
        end else begin
            dl_valid_q[0] <= rd_valid;
            dl_addr_q[0]  <= {rd_addr_3, rd_addr_2, rd_addr_1, rd_addr_0};
            for (int k = 1; k < LAT; k++) begin
                dl_valid_q[k] <= dl_valid_q[k-1];
                dl_addr_q[k]  <= dl_addr_q[k-1];
            end
        end
    end

    // Data arrives in the same cycle as the delayed address; both are captured together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen     <= 1'b0;
            waddr_0 <= '0;
            waddr_1 <= '0;
            waddr_2 <= '0;
            waddr_3 <= '0;
            wdata_0 <= '0;
            wdata_1 <= '0;
            wdata_2 <= '0;
            wdata_3 <= '0;
        end else begin
            wen <= line_valid;
            if (line_valid) begin
                waddr_0 <= line_addr[0*addr_width +: addr_width];
                waddr_1 <= line_addr[1*addr_width +: addr_width];
                waddr_2 <= line_addr[2*addr_width +: addr_width];
                waddr_3 <= line_addr[3*addr_width +: addr_width];
                wdata_0 <= d0;
                wdata_1 <= d1;
                wdata_2 <= d2;
                wdata_3 <= d3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            busy       <= 1'b0;
            stage_done <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                    end
                end
                StRun: begin
                    if (wen) begin
                        if (cnt_q == cnt_last) begin
                            state_q    <= StDone;
                            stage_done <= 1'b1;
                            busy       <= 1'b0;
                        end
                        if (cnt_q < cnt_max) cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q    <= StIdle;
                    stage_done <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef WB_OVERRUN_CHK_EN
    // Setting wins over the clear so an overrun on the accepting cycle is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if ((state_q == StIdle && start && rd_valid) ||
                     (line_valid && state_q != StRun)) begin
            err <= 1'b1;
        end else if (state_q == StIdle && start) begin
            err <= 1'b0;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_bank_wb.sv
// Randomized and directed bench for ntt_bank_wb against a cycle-indexed history model.
module tb_ntt_bank_wb;
    localparam int unsigned DW     = 12;
    localparam int unsigned AW     = 7;
    localparam int unsigned LAT    = 13;
    localparam int unsigned GROUPS = 128;
    localparam int          N      = 4096;
`ifdef WB_OVERRUN_CHK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif
    localparam int PIdle = 0, PRun = 1, PDone = 2;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, rd_valid = 1'b0;
    logic [AW-1:0] rd_addr_0 = '0, rd_addr_1 = '0, rd_addr_2 = '0, rd_addr_3 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic          wen, busy, stage_done, err;
    logic [AW-1:0] waddr_0, waddr_1, waddr_2, waddr_3;
    logic [DW-1:0] wdata_0, wdata_1, wdata_2, wdata_3;

    ntt_bank_wb #(.data_width(DW), .addr_width(AW), .LAT(LAT), .GROUPS(GROUPS)) dut (
        .clk(clk), .rst(rst), .start(start), .rd_valid(rd_valid),
        .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_addr_3(rd_addr_3), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .wen(wen), .waddr_0(waddr_0), .waddr_1(waddr_1), .waddr_2(waddr_2),
        .waddr_3(waddr_3), .wdata_0(wdata_0), .wdata_1(wdata_1), .wdata_2(wdata_2),
        .wdata_3(wdata_3), .busy(busy), .stage_done(stage_done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // History of what was presented to the DUT in each cycle.
    bit              v_hist [N];
    bit              s_hist [N];
    logic [4*AW-1:0] a_hist [N];
    logic [4*DW-1:0] d_hist [N];

    // Expected outputs for the current cycle.
    logic            m_wen;
    logic [4*AW-1:0] m_waddr;
    logic [4*DW-1:0] m_wdata;
    logic            m_err;
    int              m_phase;
    int              m_writes;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [4*AW-1:0] a;
        logic [4*DW-1:0] d;
        a = {waddr_3, waddr_2, waddr_1, waddr_0};
        d = {wdata_3, wdata_2, wdata_1, wdata_0};
        check("wen", wen, m_wen);
        for (int i = 0; i < 4; i++) begin
            check("waddr", a[i*AW +: AW], m_waddr[i*AW +: AW]);
            check("wdata", d[i*DW +: DW], m_wdata[i*DW +: DW]);
        end
        check("busy", busy, m_phase == PRun);
        check("stage_done", stage_done, m_phase == PDone);
        check("err", err, m_err);
    endtask

    task automatic model_clear();
        m_wen = 0; m_waddr = '0; m_wdata = '0; m_err = 0; m_phase = PIdle; m_writes = 0;
    endtask

    // Expected state for cycle c from the inputs recorded in earlier cycles.
    task automatic model_update();
        int  p;
        bit  arrive;
        p = cyc - 1;
        if (!rst) begin
            model_clear();
            return;
        end
        arrive = (p - int'(LAT) >= 0) && v_hist[p - int'(LAT)];
        if (ERR_EN) begin
            if ((m_phase == PIdle && s_hist[p] && v_hist[p]) || (arrive && m_phase != PRun))
                m_err = 1;
            else if (m_phase == PIdle && s_hist[p])
                m_err = 0;
        end
        case (m_phase)
            PIdle: if (s_hist[p]) begin m_phase = PRun; m_writes = 0; end
            PRun: if (m_wen) begin
                m_writes++;
                if (m_writes == int'(GROUPS)) m_phase = PDone;
            end
            default: m_phase = PIdle;
        endcase
        m_wen = arrive;
        if (arrive) begin
            m_waddr = a_hist[p - int'(LAT)];
            m_wdata = d_hist[p];
        end
    endtask

    task automatic step();
        v_hist[cyc] = rst && rd_valid;
        s_hist[cyc] = rst && start;
        a_hist[cyc] = {rd_addr_3, rd_addr_2, rd_addr_1, rd_addr_0};
        d_hist[cyc] = {d3, d2, d1, d0};
        @(posedge clk);
        cyc++;
        #1;
        if (cyc >= N) begin
            errors++;
            $display("FAIL history overflow cycle %0d", cyc);
            $fatal(1, "history overflow");
        end
        model_update();
        check_all();
    endtask

    task automatic drive(input logic v, input logic s, input logic [4*AW-1:0] a,
                         input logic [4*DW-1:0] d);
        rd_valid = v;
        start    = s;
        {rd_addr_3, rd_addr_2, rd_addr_1, rd_addr_0} = a;
        {d3, d2, d1, d0} = d;
    endtask

    function automatic logic [4*DW-1:0] rand_d();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[4*DW-1:0];
    endfunction

    task automatic apply_reset(input int n);
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin v_hist[k] = 0; s_hist[k] = 0; end
        model_clear();
        #1;
        check_all();
        repeat (n) step();
        rst = 1'b1;
    endtask

    task automatic run_stage(input int restart_at);
        int base, rr;
        logic [AW-1:0] a;
        logic [4*DW-1:0] dd;
        base = cyc;
        drive(0, 1, '0, rand_d());
        step();
        for (int r = 1; r <= 150; r++) begin
            a = AW'(r - 1);
            if (r >= 14 && r <= 141)
                dd = {DW'(300 + r - 14), DW'(200 + r - 14), DW'(100 + r - 14), DW'(r - 14)};
            else
                dd = rand_d();
            drive(r <= 128, r == restart_at, {a, a, a, a}, dd);
            step();
            rr = cyc - base;
            if (rr == 14) check("wen_before_first", wen, 0);
            if (rr == 15) begin
                check("wdata2_first", wdata_2, 200);
                check("waddr0_first", waddr_0, 0);
            end
            if (rr == 142) begin
                check("wen_last", wen, 1);
                check("waddr3_last", waddr_3, 127);
                check("done_early", stage_done, 0);
            end
            if (rr == 143) begin
                check("stage_done", stage_done, 1);
                check("busy_fall", busy, 0);
                check("wen_after_last", wen, 0);
            end
            if (rr == 144) check("done_width", stage_done, 0);
        end
    endtask

    initial begin
        int base, rr;
        logic [AW-1:0] a;
        logic [31:0] t;
        model_clear();
        drive(0, 0, '0, '0);
        #1;
        check("rst_wen", wen, 0);
        check("rst_busy", busy, 0);
        apply_reset(3);

        // Full stage, back-to-back beats.
        run_stage(0);

        // Gapped issue: three beats, stage stays open.
        apply_reset(2);
        base = cyc;
        drive(0, 1, '0, rand_d());
        step();
        for (int r = 1; r <= 40; r++) begin
            a = AW'(r * 5);
            drive(r == 1 || r == 3 || r == 10, 0, {a, a, a, a}, rand_d());
            step();
            rr = cyc - base;
            if (rr == 16) check("gap_wen_16", wen, 0);
            if (rr == 24) begin
                check("gap_wen_24", wen, 1);
                check("gap_waddr_24", waddr_2, 50);
            end
            if (rr == 40) begin
                check("gap_no_done", stage_done, 0);
                check("gap_still_busy", busy, 1);
            end
        end

        // Reset mid-stage discards in-flight beats.
        apply_reset(2);
        base = cyc;
        drive(0, 1, '0, rand_d());
        step();
        for (int r = 1; r < 50; r++) begin
            a = AW'(r);
            drive(1, 0, {a, a, a, a}, rand_d());
            step();
        end
        apply_reset(2);
        check("rst_mid_busy", busy, 0);
        for (int r = 52; r <= 70; r++) begin
            drive(0, 0, '0, rand_d());
            step();
            rr = cyc - base;
            if (rr >= 53 && rr <= 66) check("no_wen_after_rst", wen, 0);
        end

        // Restart while running is ignored.
        apply_reset(2);
        run_stage(60);

        // Beat with no stage open.
        apply_reset(2);
        base = cyc;
        for (int r = 0; r <= 25; r++) begin
            a = AW'(r);
            drive(r == 5, 0, {a, a, a, a}, rand_d());
            step();
            rr = cyc - base;
            if (rr == 19) begin
                check("idle_wen", wen, 1);
                check("idle_err", err, ERR_EN);
            end
        end
        drive(0, 1, '0, rand_d());
        step();
        check("err_cleared", err, 0);
        check("busy_after_start", busy, 1);

        // Random traffic, starts and resets.
        apply_reset(2);
        for (int r = 0; r < 2000; r++) begin
            if ($urandom_range(999) < 3) begin
                apply_reset(int'($urandom_range(2, 1)));
            end else begin
                t = $urandom();
                drive($urandom_range(9) < 7, $urandom_range(99) < 2, t[4*AW-1:0], rand_d());
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
